rr_arb4: RTL

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-channel round-robin arbiter with registered one-hot grant.
// Each grant is followed by a forced idle gap; long holds are cut by timeout.
module rr_arb4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic ack,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic busy,
  output logic tout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gidx_q, gidx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       tout_q, tout_d;

  logic [3:0] req_v;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] pick;
  logic       held;
  logic       hit;

  assign req_v = {req3, req2, req1, req0};

  // Rotate so bit 0 is the channel at the pointer.
  always_comb begin
    rot = req_v;
    unique case (ptr_q)
      2'd0: rot = req_v;
      2'd1: rot = {req_v[0], req_v[3:1]};
      2'd2: rot = {req_v[1:0], req_v[3:2]};
      2'd3: rot = {req_v[2:0], req_v[3]};
      default: rot = req_v;
    endcase
  end

  always_comb begin
    off = 2'd0;
    priority case (1'b1)
      rot[0]: off = 2'd0;
      rot[1]: off = 2'd1;
      rot[2]: off = 2'd2;
      rot[3]: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign pick = ptr_q + off;
  assign held = req_v[gidx_q];
  assign hit  = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req_v) begin
          state_d = GRANT;
          gidx_d  = pick;
          cnt_d   = 8'd0;
          gnt_d   = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if (ack || !held || hit) begin
          state_d = GAP;
          gnt_d   = 4'b0000;
          ptr_d   = gidx_q + 2'd1;
          // ack and request drop outrank the timeout flag
          tout_d  = !ack && held && hit;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gidx_q  <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
    end
  end

  assign g0   = gnt_q[0];
  assign g1   = gnt_q[1];
  assign g2   = gnt_q[2];
  assign g3   = gnt_q[3];
  assign busy = busy_q;
  assign tout = tout_q;

endmodule
